// File: rtl/if2_id_fetch_buffer.sv
// Fetch queue between IF2 and ID: takes up to two {PC, inst} pairs per cycle
// and presents the two oldest to decode, with back-pressure to the IF stall path.
module if2_id_fetch_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [31:0]                i_PC1,
  input  logic [31:0]                i_PC2,
  input  logic [31:0]                i_inst1,
  input  logic [31:0]                i_inst2,
  input  logic [1:0]                 i_is_valid,
  input  logic                       flush_BR,
  input  logic                       stall_ID,
  output logic [31:0]                o_PC1,
  output logic [31:0]                o_PC2,
  output logic [31:0]                o_inst1,
  output logic [31:0]                o_inst2,
  output logic [1:0]                 o_is_valid,
  output logic                       o_stall_IF,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] head, tail, head_p1, tail_p1;
  logic [CW-1:0] count, count_next;
  logic          push_en, v0, v1;
  logic [1:0]    n_push, n_pop;

  assign head_p1    = head + AW'(1);
  assign tail_p1    = tail + AW'(1);
  assign o_count    = count;
  // Registered count only: a same-cycle pop does not relieve the stall.
  assign o_stall_IF = count > CW'(DEPTH - 2);

  always_comb begin
    push_en    = !o_stall_IF && !flush_BR;
    n_push     = '0;
    n_pop      = '0;
    v0         = (count != '0) && !flush_BR;
    v1         = (count >= CW'(2)) && !flush_BR;
    if (push_en)
      n_push = {1'b0, i_is_valid[0]} + {1'b0, i_is_valid[1]};
    if (!stall_ID && !flush_BR)
      n_pop = {1'b0, v0} + {1'b0, v1};
    count_next = count + CW'(n_push) - CW'(n_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_BR) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_pop);
      tail  <= tail + AW'(n_push);
      count <= count_next;
    end
  end

  // Valid slots are compacted: a lone slot 1 lands at tail.
  always_ff @(posedge clk) begin
    if (push_en) begin
      unique case (i_is_valid)
        2'b11: begin
          pc_mem[tail]      <= i_PC1;
          inst_mem[tail]    <= i_inst1;
          pc_mem[tail_p1]   <= i_PC2;
          inst_mem[tail_p1] <= i_inst2;
        end
        2'b01: begin
          pc_mem[tail]   <= i_PC1;
          inst_mem[tail] <= i_inst1;
        end
        2'b10: begin
          pc_mem[tail]   <= i_PC2;
          inst_mem[tail] <= i_inst2;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_is_valid = {v1, v0};
    o_PC1      = v0 ? pc_mem[head]      : '0;
    o_inst1    = v0 ? inst_mem[head]    : '0;
    o_PC2      = v1 ? pc_mem[head_p1]   : '0;
    o_inst2    = v1 ? inst_mem[head_p1] : '0;
  end

endmodule

// File: tb/tb_if2_id_fetch_buffer.sv
// Scoreboard bench for if2_id_fetch_buffer: a queue of accepted {PC, inst}
// pairs is the reference; a negedge monitor compares and retires entries.
module tb_if2_id_fetch_buffer;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   i_PC1, i_PC2, i_inst1, i_inst2;
  logic [1:0]    i_is_valid;
  logic          flush_BR, stall_ID;
  logic [31:0]   o_PC1, o_PC2, o_inst1, o_inst2;
  logic [1:0]    o_is_valid;
  logic          o_stall_IF;
  logic [CW-1:0] o_count;

  entry_t q[$];
  entry_t pend[$];
  int     checks = 0;
  int     errors = 0;
  bit     mon_en = 1'b0;
  logic [31:0] pc_seq = 32'h1c00_1000;

  if2_id_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .i_PC1(i_PC1), .i_PC2(i_PC2), .i_inst1(i_inst1), .i_inst2(i_inst2),
    .i_is_valid(i_is_valid), .flush_BR(flush_BR), .stall_ID(stall_ID),
    .o_PC1(o_PC1), .o_PC2(o_PC2), .o_inst1(o_inst1), .o_inst2(o_inst2),
    .o_is_valid(o_is_valid), .o_stall_IF(o_stall_IF), .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drive one cycle, record what the buffer should accept,
  // then commit those entries once the edge has passed.
  task automatic drive(input logic [1:0] mask, input logic [31:0] pc1, input logic [31:0] pc2,
                       input logic [31:0] in1, input logic [31:0] in2,
                       input logic fl, input logic st);
    i_is_valid = mask; i_PC1 = pc1; i_PC2 = pc2; i_inst1 = in1; i_inst2 = in2;
    flush_BR = fl; stall_ID = st;
    pend.delete();
    if (!fl && !(q.size() > DEPTH - 2)) begin
      if (mask[0]) pend.push_back('{pc: pc1, inst: in1});
      if (mask[1]) pend.push_back('{pc: pc2, inst: in2});
    end
    @(posedge clk);
    #1;
    foreach (pend[i]) q.push_back(pend[i]);
  endtask

  task automatic drive_rand(input logic [1:0] mask, input logic fl, input logic st);
    logic [31:0] a, b;
    a = pc_seq; b = pc_seq + 32'd4;
    pc_seq = pc_seq + 32'd8;
    drive(mask, a, b, $urandom, $urandom, fl, st);
  endtask

  always @(negedge clk) begin
    if (mon_en && rstn) begin
      int     n;
      logic   e0, e1;
      entry_t f0, f1;
      n  = q.size();
      e0 = (n >= 1) && !flush_BR;
      e1 = (n >= 2) && !flush_BR;
      f0 = e0 ? q[0] : '0;
      f1 = e1 ? q[1] : '0;
      chk("count", 64'(o_count), 64'(n));
      chk("stall_IF", 64'(o_stall_IF), 64'(n > DEPTH - 2));
      chk("is_valid", 64'(o_is_valid), 64'({e1, e0}));
      if (o_is_valid != 2'b00 || e0) begin
        chk("slot0", {o_PC1, o_inst1}, f0);
        chk("slot1", {o_PC2, o_inst2}, f1);
      end
      if (flush_BR) q.delete();
      else if (!stall_ID) begin
        if (e0) void'(q.pop_front());
        if (e1) void'(q.pop_front());
      end
    end
  end

  initial begin
    rstn = 1'b0; i_is_valid = '0; i_PC1 = '0; i_PC2 = '0; i_inst1 = '0; i_inst2 = '0;
    flush_BR = 1'b0; stall_ID = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_valid", 64'(o_is_valid), 64'd0);
    chk("rst_stall", 64'(o_stall_IF), 64'd0);
    chk("rst_data", {o_PC1, o_PC2, o_inst1, o_inst2} == '0, 64'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // First pair appears next cycle, oldest in slot 0.
    drive(2'b11, 32'h1c00_0000, 32'h1c00_0004, 32'h0000_0013, 32'h0010_0093, 1'b0, 1'b1);
    // Keep pushing under decode stall until the buffer saturates.
    repeat (5) drive_rand(2'b11, 1'b0, 1'b1);
    drive_rand(2'b00, 1'b1, 1'b1);

    // Lone slot 1 into an empty buffer lands in the oldest position.
    drive(2'b10, 32'h1c00_0010, 32'h1c00_0014, 32'hdead_beef, 32'h0020_0113, 1'b0, 1'b1);
    drive_rand(2'b00, 1'b1, 1'b1);

    // count=6 then push 2 and pop 2 together.
    repeat (3) drive_rand(2'b11, 1'b0, 1'b1);
    repeat (4) drive_rand(2'b11, 1'b0, 1'b0);
    drive_rand(2'b00, 1'b1, 1'b1);

    // count=5, then flush alongside a push and an open decode.
    repeat (2) drive_rand(2'b11, 1'b0, 1'b1);
    drive_rand(2'b01, 1'b0, 1'b1);
    drive_rand(2'b11, 1'b1, 1'b0);
    drive_rand(2'b11, 1'b0, 1'b1);

    // Random traffic wraps the pointers many times.
    for (int i = 0; i < 300; i++)
      drive_rand(2'($urandom_range(0, 3)), ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 40));

    // Asynchronous reset with four entries held.
    drive_rand(2'b00, 1'b1, 1'b1);
    repeat (2) drive_rand(2'b11, 1'b0, 1'b1);
    mon_en = 1'b0;
    i_is_valid = 2'b11;
    #1;
    chk("pre_rst_count", 64'(o_count), 64'd4);
    rstn = 1'b0;
    #1;
    chk("async_count", 64'(o_count), 64'd0);
    chk("async_valid", 64'(o_is_valid), 64'd0);
    chk("async_data", {o_PC1, o_PC2, o_inst1, o_inst2} == '0, 64'd1);
    @(posedge clk);
    #1;
    chk("held_count", 64'(o_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
